multi_cycle_ctrl: RTL and testbench

//   Next-generation multicycle CPU control FSM: decodes a latched opcode, sequences the
//   IF/ID/EXE/MEM/WB states and drives datapath controls. Adds a variable-latency memory

---
 rtl/multi_cycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multicycle CPU control FSM with memory handshake, HALT and instret
// Optional feature: define MCC_TRAP_EN to route unknown opcodes through a one-cycle TRAP state.
module multi_cycle_ctrl #(
    parameter int OPW   = 6,
    parameter int CNT_W = 32,
    parameter int ALUW  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [OPW-1:0]   opCode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic             WrRegDSrc,
    output logic             InsMemRW,
    output logic             RD,
    output logic             WR,
    output logic [1:0]       ExtSel,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic [ALUW-1:0]  ALUOp,
    output logic [3:0]       StatusOut,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXE_R = 4'd2,
        S_EXE_B = 4'd3,
        S_EXE_M = 4'd4,
        S_MEM   = 4'd5,
        S_WB_R  = 4'd6,
        S_WB_M  = 4'd7,
        S_HALT  = 4'd8,
        S_TRAP  = 4'd9
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t     state, state_n;
    logic [5:0] op_q;
    logic       op_ill_q;
    logic       op_hi_bad;
    logic [5:0] cur_code;
    logic       cur_ill;
    logic       retire;

    logic       is_alu, is_lw, is_sw, is_beq, is_bne;
    logic       is_j, is_jr, is_jal, is_halt;
    logic [2:0] dec_alu;
    logic       dec_src_a, dec_src_b;
    logic [1:0] dec_ext, dec_rdst;
    logic [2:0] alu_op3;

    // Opcode bits above the 6-bit field must be zero for a legal instruction
    generate
        if (OPW > 6) begin : g_hi_bits
            assign op_hi_bad = |opCode[OPW-1:6];
        end else begin : g_no_hi_bits
            assign op_hi_bad = 1'b0;
        end
    endgenerate

    // ID decodes the live opcode (op_q is still loading); later states use the latched copy
    assign cur_code = (state == S_ID) ? opCode[5:0] : op_q;
    assign cur_ill  = (state == S_ID) ? op_hi_bad   : op_ill_q;

    always_comb begin
        is_alu    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jr     = 1'b0;
        is_jal    = 1'b0;
        is_halt   = 1'b0;
        dec_alu   = 3'b000;
        dec_src_a = 1'b0;
        dec_src_b = 1'b0;
        dec_ext   = 2'b10;
        dec_rdst  = 2'b00;
        if (!cur_ill) begin
            case (cur_code)
                OP_ADD:  begin is_alu = 1'b1; dec_rdst = 2'b10; end
                OP_SUB:  begin is_alu = 1'b1; dec_alu = 3'b001; dec_rdst = 2'b10; end
                OP_ADDI: begin is_alu = 1'b1; dec_src_b = 1'b1; dec_rdst = 2'b01; end
                OP_OR:   begin is_alu = 1'b1; dec_alu = 3'b101; dec_rdst = 2'b10; end
                OP_AND:  begin is_alu = 1'b1; dec_alu = 3'b110; dec_rdst = 2'b10; end
                OP_ORI:  begin
                    is_alu = 1'b1; dec_alu = 3'b101; dec_src_b = 1'b1;
                    dec_ext = 2'b01; dec_rdst = 2'b01;
                end
                OP_SLL:  begin
                    is_alu = 1'b1; dec_alu = 3'b100; dec_src_a = 1'b1;
                    dec_ext = 2'b00; dec_rdst = 2'b10;
                end
                OP_SLT:  begin is_alu = 1'b1; dec_alu = 3'b010; dec_rdst = 2'b10; end
                OP_SLTI: begin
                    is_alu = 1'b1; dec_alu = 3'b010; dec_src_b = 1'b1; dec_rdst = 2'b01;
                end
                OP_LW:   begin is_lw = 1'b1; dec_src_b = 1'b1; dec_rdst = 2'b01; end
                OP_SW:   begin is_sw = 1'b1; dec_src_b = 1'b1; end
                OP_BEQ:  begin is_beq = 1'b1; dec_alu = 3'b001; end
                OP_BNE:  begin is_bne = 1'b1; dec_alu = 3'b001; end
                OP_J:    is_j    = 1'b1;
                OP_JR:   is_jr   = 1'b1;
                OP_JAL:  is_jal  = 1'b1;
                OP_HALT: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IF;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IF:    state_n = mem_ack ? S_ID : S_IF;
            S_ID: begin
                if (is_halt)
                    state_n = S_HALT;
                else if (is_j || is_jr || is_jal)
                    state_n = S_IF;
                else if (is_lw || is_sw)
                    state_n = S_EXE_M;
                else if (is_beq || is_bne)
                    state_n = S_EXE_B;
                else if (is_alu)
                    state_n = S_EXE_R;
                else
`ifdef MCC_TRAP_EN
                    state_n = S_TRAP;
`else
                    state_n = S_EXE_R;
`endif
            end
            S_EXE_R: state_n = S_WB_R;
            S_WB_R:  state_n = S_IF;
            S_EXE_B: state_n = S_IF;
            S_EXE_M: state_n = S_MEM;
            S_MEM: begin
                if (mem_ack)
                    state_n = is_lw ? S_WB_M : S_IF;
            end
            S_WB_M:  state_n = S_IF;
            S_HALT:  state_n = S_HALT;
            S_TRAP:  state_n = S_IF;
            default: state_n = S_IF;
        endcase
    end

`ifdef MCC_TRAP_EN
    logic trap_c;
`endif

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        InsMemRW  = 1'b0;
        RD        = 1'b0;
        WR        = 1'b0;
        ExtSel    = 2'b00;
        PCSrc     = 2'b00;
        RegDst    = 2'b00;
        alu_op3   = 3'b000;
`ifdef MCC_TRAP_EN
        trap_c    = 1'b0;
`endif
        // Decoded datapath selects are presented from ID through writeback
        if (state inside {S_ID, S_EXE_R, S_EXE_B, S_EXE_M, S_MEM, S_WB_R, S_WB_M}) begin
            alu_op3 = dec_alu;
            ALUSrcA = dec_src_a;
            ALUSrcB = dec_src_b;
            ExtSel  = dec_ext;
            RegDst  = dec_rdst;
        end
        case (state)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = mem_ack;
            end
            S_ID: begin
                if (is_j || is_jr || is_jal) begin
                    PCWre = 1'b1;
                    PCSrc = is_jr ? 2'b10 : 2'b11;
                end
                if (is_jal) begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end
            end
            S_WB_R: begin
                RegWre    = is_alu;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
            end
            S_EXE_B: begin
                PCWre = 1'b1;
                PCSrc = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                RD    = is_lw;
                WR    = is_sw;
                PCWre = is_sw && mem_ack;
            end
            S_WB_M: begin
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
            end
`ifdef MCC_TRAP_EN
            S_TRAP: begin
                trap_c = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = 2'b11;
            end
`endif
            default: ;
        endcase
    end

`ifdef MCC_TRAP_EN
    assign trap = trap_c;
`else
    assign trap = 1'b0;
`endif

    assign ALUOp     = ALUW'(alu_op3);
    assign StatusOut = state;
    assign halted    = (state == S_HALT);
    assign retire    = PCWre && (state != S_TRAP);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q     <= 6'd0;
            op_ill_q <= 1'b0;
        end else if (state == S_ID) begin
            op_q     <= opCode[5:0];
            op_ill_q <= op_hi_bad;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;
    localparam int OPW   = 8;
    localparam int CNT_W = 4;
    localparam int ALUW  = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [OPW-1:0]   opCode = '0;
    logic             zero = 1'b0;
    logic             mem_ack = 1'b0;
    logic             PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc;
    logic             InsMemRW, RD, WR, halted, trap;
    logic [1:0]       ExtSel, PCSrc, RegDst;
    logic [ALUW-1:0]  ALUOp;
    logic [3:0]       StatusOut;
    logic [CNT_W-1:0] instret;

    multi_cycle_ctrl #(.OPW(OPW), .CNT_W(CNT_W), .ALUW(ALUW)) dut (
        .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .mem_ack(mem_ack),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .InsMemRW(InsMemRW), .RD(RD), .WR(WR),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp),
        .StatusOut(StatusOut), .halted(halted), .trap(trap), .instret(instret)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [13:0] sb_q[$];
    logic [13:0] obs;
    logic [3:0]  exp_ret = 4'd0;

    assign obs = {StatusOut, PCWre, RegWre, RD, WR, PCSrc, DBDataSrc, InsMemRW, IRWre, halted};

    // {op6, aluop3, srcA, srcB, extsel2, regdst2}
    logic [14:0] alu_tbl [0:8] = '{
        {6'b000000, 3'b000, 1'b0, 1'b0, 2'b10, 2'b10},
        {6'b000001, 3'b001, 1'b0, 1'b0, 2'b10, 2'b10},
        {6'b000010, 3'b000, 1'b0, 1'b1, 2'b10, 2'b01},
        {6'b010000, 3'b101, 1'b0, 1'b0, 2'b10, 2'b10},
        {6'b010001, 3'b110, 1'b0, 1'b0, 2'b10, 2'b10},
        {6'b010010, 3'b101, 1'b0, 1'b1, 2'b01, 2'b01},
        {6'b011000, 3'b100, 1'b1, 1'b0, 2'b00, 2'b10},
        {6'b100110, 3'b010, 1'b0, 1'b0, 2'b10, 2'b10},
        {6'b100111, 3'b010, 1'b0, 1'b1, 2'b10, 2'b01}
    };

    function automatic logic [13:0] mk(input logic [3:0] st, input logic pcw, input logic rw,
                                       input logic rd, input logic wr, input logic [1:0] pcsrc,
                                       input logic db, input logic ins, input logic ir,
                                       input logic h);
        return {st, pcw, rw, rd, wr, pcsrc, db, ins, ir, h};
    endfunction

    task automatic cmp(input string tag);
        logic [13:0] e;
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic adv();
        @(negedge CLK);
    endtask

    task automatic step(input string tag);
        cmp(tag);
        adv();
    endtask

    task automatic fetch(input logic [7:0] op);
        opCode  = op;
        mem_ack = 1'b1;
        sb_q.push_back(mk(4'd0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0));
        step("if");
    endtask

    // ID with mem_ack still high (must be ignored); opcode scrambled afterwards to prove op_q latch
    task automatic decode();
        sb_q.push_back(mk(4'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step("id");
        mem_ack = 1'b0;
        opCode  = 8'hFF;
    endtask

    task automatic branch(input logic [7:0] op, input logic z, input logic [1:0] pcsrc);
        fetch(op);
        zero = ~z;
        decode();
        zero = z;
        sb_q.push_back(mk(4'd3, 1, 0, 0, 0, pcsrc, 0, 0, 0, 0));
        step("exe_b");
        zero = 1'b0;
        exp_ret++;
        chk("instret_branch", 32'(instret), 32'(exp_ret));
    endtask

    task automatic jump(input logic [7:0] op, input logic [1:0] pcsrc, input logic rw);
        fetch(op);
        sb_q.push_back(mk(4'd1, 1, rw, 0, 0, pcsrc, 0, 0, 0, 0));
        cmp("id_jump");
        if (rw) begin
            chk("jal_regdst", 32'(RegDst), 32'd0);
            chk("jal_wrregdsrc", 32'(WrRegDSrc), 32'd0);
        end
        adv();
        mem_ack = 1'b0;
        exp_ret++;
        chk("instret_jump", 32'(instret), 32'(exp_ret));
    endtask

    task automatic nop_op(input logic [7:0] op);
        fetch(op);
        decode();
`ifdef MCC_TRAP_EN
        sb_q.push_back(mk(4'd9, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0));
        cmp("trap_state");
        chk("trap_pulse", 32'(trap), 32'd1);
        adv();
        chk("trap_clear", 32'(trap), 32'd0);
`else
        sb_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step("nop_exe");
        sb_q.push_back(mk(4'd6, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        cmp("nop_wb");
        chk("nop_trap", 32'(trap), 32'd0);
        adv();
        exp_ret++;
`endif
        chk("instret_nop", 32'(instret), 32'(exp_ret));
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        sb_q.push_back(mk(4'd0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
        cmp("reset");
        chk("reset_instret", 32'(instret), 32'd0);
        chk("reset_aluop", 32'(ALUOp), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        chk("reset_extsel", 32'(ExtSel), 32'd0);
        RST = 1'b1;
        adv();

        // IF stalls until mem_ack
        opCode = 8'h00;
        repeat (2) begin
            sb_q.push_back(mk(4'd0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
            step("if_stall");
        end

        for (int i = 0; i < 9; i++) begin
            logic [14:0] r;
            r = alu_tbl[i];
            fetch({2'b00, r[14:9]});
            decode();
            sb_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
            cmp("exe_r");
            chk("aluop", 32'(ALUOp), 32'({1'b0, r[8:6]}));
            chk("alusrca", 32'(ALUSrcA), 32'(r[5]));
            chk("alusrcb", 32'(ALUSrcB), 32'(r[4]));
            chk("extsel", 32'(ExtSel), 32'(r[3:2]));
            chk("regdst", 32'(RegDst), 32'(r[1:0]));
            adv();
            sb_q.push_back(mk(4'd6, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
            cmp("wb_r");
            chk("wb_r_wrregdsrc", 32'(WrRegDSrc), 32'd1);
            adv();
            exp_ret++;
            chk("instret_alu", 32'(instret), 32'(exp_ret));
        end

        // lw with three wait cycles in MEM
        fetch(8'b00110000);
        decode();
        sb_q.push_back(mk(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        cmp("exe_m_lw");
        chk("lw_alusrcb", 32'(ALUSrcB), 32'd1);
        chk("lw_regdst", 32'(RegDst), 32'd1);
        adv();
        repeat (3) begin
            sb_q.push_back(mk(4'd5, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
            step("mem_lw_wait");
        end
        mem_ack = 1'b1;
        sb_q.push_back(mk(4'd5, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        step("mem_lw_ack");
        mem_ack = 1'b0;
        sb_q.push_back(mk(4'd7, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0));
        step("wb_m");
        exp_ret++;
        chk("instret_lw", 32'(instret), 32'(exp_ret));

        // sw
        fetch(8'b00110001);
        decode();
        sb_q.push_back(mk(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step("exe_m_sw");
        sb_q.push_back(mk(4'd5, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        step("mem_sw_wait");
        mem_ack = 1'b1;
        sb_q.push_back(mk(4'd5, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        step("mem_sw_ack");
        mem_ack = 1'b0;
        exp_ret++;
        chk("instret_sw", 32'(instret), 32'(exp_ret));

        branch(8'b00110100, 1'b1, 2'b01);
        branch(8'b00110100, 1'b0, 2'b00);
        branch(8'b00110101, 1'b1, 2'b00);
        branch(8'b00110101, 1'b0, 2'b01);

        jump(8'b00111000, 2'b11, 1'b0);
        jump(8'b00111001, 2'b10, 1'b0);
        jump(8'b00111010, 2'b11, 1'b1);

        nop_op(8'b00001111);
        nop_op(8'b01000000);

        // Async reset during sw MEM: WR drops immediately, no retire
        fetch(8'b00110001);
        decode();
        sb_q.push_back(mk(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step("exe_m_sw2");
        sb_q.push_back(mk(4'd5, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        cmp("mem_sw2");
        #1 RST = 1'b0;
        #1;
        chk("rst_wr_drop", 32'(WR), 32'd0);
        chk("rst_state", 32'(StatusOut), 32'd0);
        chk("rst_insmem", 32'(InsMemRW), 32'd1);
        chk("rst_instret", 32'(instret), 32'd0);
        adv();
        adv();
        chk("rst_hold_instret", 32'(instret), 32'd0);
        RST = 1'b1;
        exp_ret = 4'd0;

        fetch(8'b00000000);
        decode();
        sb_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step("exe_r_post");
        sb_q.push_back(mk(4'd6, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        step("wb_r_post");
        exp_ret++;
        chk("instret_post_reset", 32'(instret), 32'(exp_ret));

        // HALT is sticky
        fetch(8'b00111111);
        decode();
        for (int c = 0; c < 20; c++) begin
            mem_ack = 1'($urandom_range(0, 1));
            opCode  = 8'($urandom_range(0, 255));
            zero    = 1'($urandom_range(0, 1));
            sb_q.push_back(mk(4'd8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
            step("halt");
        end
        chk("halt_instret", 32'(instret), 32'(exp_ret));
        RST = 1'b0;
        #1;
        chk("halt_rst_state", 32'(StatusOut), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_instret", 32'(instret), 32'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
